// File: rtl/lap_timer.sv
// lap_timer: MM:SS stopwatch / countdown with lap-hold and a multiplexed
// active-low 7-segment display.
//   clk, rst_n          system clock, synchronous active-low reset
//   sw[7:0]             down-mode preset, BCD minutes (tens, units)
//   mode                0 = count up, 1 = count down (latched on clear)
//   btnP, btnR, btnL    asynchronous start/pause, clear, lap-hold buttons
//   seg, dp             active-low segments (g..a) and decimal point
//   an                  active-low one-hot digit enable
//   done                high while the countdown has finished
module lap_timer #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        sw,
    input  logic              mode,
    input  logic              btnP,
    input  logic              btnR,
    input  logic              btnL,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an,
    output logic              done
);
    localparam int unsigned PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW  = $clog2(DIGITS);
    localparam int unsigned DCW = $clog2(DEB_CYCLES + 2);
    localparam int unsigned NB  = 3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    // Largest value of counter digit i (MM:SS radices, then decimal).
    function automatic logic [3:0] dmax(input int unsigned i);
        return (i == 1 || i == 3) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Button synchronise + debounce; bit 0 = P, 1 = R, 2 = L
    // ------------------------------------------------------------------
    logic [NB-1:0]  btn, sync1, sync2, deb, armed, pulse;
    logic [DCW-1:0] deb_cnt [NB];

    assign btn = {btnL, btnR, btnP};

    // A button held through reset must be seen released (counting the two
    // reset-cleared synchroniser stages) before its press is honoured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            armed <= '0;
            pulse <= '0;
            for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            for (int i = 0; i < NB; i++) begin
                pulse[i] <= 1'b0;
                if (!armed[i]) begin
                    if (sync2[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] == DCW'(DEB_CYCLES + 1)) begin
                        armed[i]   <= 1'b1;
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DCW'(1);
                    end
                end else if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
                    deb[i]     <= sync2[i];
                    pulse[i]   <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DCW'(1);
                end
            end
        end
    end

    logic p_p, p_r, p_l;
    assign p_p = pulse[0];
    assign p_r = pulse[1];
    assign p_l = pulse[2];

    // ------------------------------------------------------------------
    // Counter arithmetic
    // ------------------------------------------------------------------
    state_t                   state, state_n;
    logic [DIGITS-1:0][3:0]   cnt, snap, inc, dec, ld, disp;
    logic [PW-1:0]            presc;
    logic                     down_l, hold;
    logic                     carry, borrow, cnt_zero, dec_zero, tick, lap_tgl;

    // BCD increment with carry; all-max rolls over to all-zero.
    always_comb begin
        inc   = cnt;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (cnt[i] >= dmax(i)) begin
                    inc[i] = 4'd0;
                end else begin
                    inc[i] = cnt[i] + 4'd1;
                    carry  = 1'b0;
                end
            end
        end
    end

    // BCD decrement with borrow; only applied while the count is non-zero.
    always_comb begin
        dec    = cnt;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (cnt[i] == 4'd0) begin
                    dec[i] = dmax(i);
                end else begin
                    dec[i] = cnt[i] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    assign cnt_zero = (cnt == '0);
    assign dec_zero = (dec == '0) && !cnt_zero;

    // Clear value: zero for up mode, clamped MM:00 preset for down mode.
    always_comb begin
        ld = '0;
        if (mode) begin
            ld[3] = (sw[7:4] > 4'd5) ? 4'd5 : sw[7:4];
            ld[2] = (sw[3:0] > 4'd9) ? 4'd9 : sw[3:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Clear overrides everything; a final down tick beats a pause request.
    always_comb begin
        state_n = state;
        lap_tgl = 1'b0;
        tick    = (state == S_RUN) && (presc == PW'(TICK_DIV - 1));
        if (p_r) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (p_p) state_n = (down_l && cnt_zero) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    lap_tgl = p_l;
                    if (tick && down_l && dec_zero) state_n = S_DONE;
                    else if (p_p)                   state_n = S_PAUSE;
                end
                S_PAUSE: begin
                    lap_tgl = p_l;
                    if (p_p) state_n = S_RUN;
                end
                S_DONE:  state_n = S_DONE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Prescaler, count register and mode latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc  <= '0;
            cnt    <= '0;
            down_l <= 1'b0;
        end else if (p_r) begin
            presc  <= '0;
            cnt    <= ld;
            down_l <= mode;
        end else if (state == S_RUN) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                if (!down_l)       cnt <= inc;
                else if (!cnt_zero) cnt <= dec;
            end
        end
    end

    // Lap hold: snapshot the running count on the toggle that engages it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold <= 1'b0;
            snap <= '0;
        end else if (p_r || state_n == S_DONE) begin
            hold <= 1'b0;
        end else if (lap_tgl) begin
            hold <= ~hold;
            if (!hold) snap <= cnt;
        end
    end

    // ------------------------------------------------------------------
    // Display scan and registered outputs
    // ------------------------------------------------------------------
    logic [SCW-1:0] scnt;
    logic [IW-1:0]  idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scnt <= '0;
            idx  <= '0;
        end else if (scnt == SCW'(SCAN_DIV - 1)) begin
            scnt <= '0;
            idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            scnt <= scnt + SCW'(1);
        end
    end

    assign disp = hold ? snap : cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg  <= 7'b1000000;
            an   <= ~DIGITS'(1);
            dp   <= 1'b1;
            done <= 1'b0;
        end else begin
            seg  <= dec7(disp[idx]);
            an   <= ~(DIGITS'(1) << idx);
            dp   <= (idx != IW'(2));
            done <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_lap_timer.sv
// Bench for lap_timer: a seconds-based model checks seg/an/dp/done every
// cycle; directed scenarios add literal checks of the display and model.
module tb_lap_timer;
    localparam int DIGITS = 4;
    localparam int TD     = 4;
    localparam int SD     = 2;
    localparam int DB     = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       mode = 1'b0;
    logic       btnP = 1'b0, btnR = 1'b0, btnL = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       done;

    int nvec = 0;
    int nerr = 0;

    lap_timer #(.DIGITS(DIGITS), .TICK_DIV(TD), .SCAN_DIV(SD), .DEB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode),
        .btnP(btnP), .btnR(btnR), .btnL(btnL),
        .seg(seg), .dp(dp), .an(an), .done(done)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    int   m_st, m_v, m_snap, m_presc, m_cyc, m_idx, m_disp;
    bit   m_down, m_hold, m_valid, m_tick;
    bit   pp, pr, pl;
    bit   d1 [3], d2 [3], dv [3], prevv [3], armd [3], np [3];
    int   run [3];
    bit   sv;
    logic [2:0] raw;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_done;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int unpat(input logic [6:0] s);
        for (int d = 0; d < 10; d++) if (pat(d) == s) return d;
        return 15;
    endfunction

    // Display digit k of a count held as total seconds.
    function automatic int digit_of(input int v, input int k);
        case (k)
            0: return v % 10;
            1: return (v / 10) % 6;
            2: return (v / 60) % 10;
            default: return (v / 600) % 6;
        endcase
    endfunction

    function automatic int load_val(input logic [7:0] s, input logic m);
        int t, u;
        if (!m) return 0;
        t = (int'(s[7:4]) > 5) ? 5 : int'(s[7:4]);
        u = (int'(s[3:0]) > 9) ? 9 : int'(s[3:0]);
        return t * 600 + u * 60;
    endfunction

    always @(posedge clk) begin
        raw = {btnL, btnR, btnP};
        if (!rst_n) begin
            m_st = M_IDLE; m_v = 0; m_snap = 0; m_presc = 0; m_cyc = 0;
            m_down = 0; m_hold = 0; pp = 0; pr = 0; pl = 0;
            for (int i = 0; i < 3; i++) begin
                d1[i] = 0; d2[i] = 0; dv[i] = 0; prevv[i] = 0; armd[i] = 0; run[i] = 0;
            end
            e_an = 4'b1110; e_seg = 7'b1000000; e_dp = 1'b1; e_done = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_idx  = (m_cyc / SD) % DIGITS;
            m_disp = m_hold ? m_snap : m_v;
            e_seg  = pat(digit_of(m_disp, m_idx));
            e_an   = ~(4'b0001 << m_idx);
            e_dp   = (m_idx != 2);
            m_cyc++;
            if (pr) begin
                m_st = M_IDLE; m_presc = 0; m_down = mode;
                m_v = load_val(sw, mode); m_hold = 0;
            end else begin
                case (m_st)
                    M_IDLE: if (pp) m_st = (m_down && m_v == 0) ? M_DONE : M_RUN;
                    M_RUN: begin
                        if (pl) begin
                            if (!m_hold) m_snap = m_v;
                            m_hold = !m_hold;
                        end
                        m_tick  = (m_presc == TD - 1);
                        m_presc = m_tick ? 0 : m_presc + 1;
                        if (m_tick) m_v = m_down ? m_v - 1 : (m_v + 1) % 3600;
                        if (m_tick && m_down && m_v == 0) begin
                            m_st = M_DONE; m_hold = 0;
                        end else if (pp) begin
                            m_st = M_PAUSE;
                        end
                    end
                    M_PAUSE: begin
                        if (pl) begin
                            if (!m_hold) m_snap = m_v;
                            m_hold = !m_hold;
                        end
                        if (pp) m_st = M_RUN;
                    end
                    default: ;
                endcase
            end
            e_done = (m_st == M_DONE);
            // Buttons: 2-cycle delay, accept a level after DB equal samples.
            for (int i = 0; i < 3; i++) begin
                sv = d2[i]; d2[i] = d1[i]; d1[i] = raw[i];
                if (sv == prevv[i]) run[i]++; else run[i] = 1;
                prevv[i] = sv;
                np[i] = 0;
                if (!armd[i]) begin
                    if (!sv && run[i] >= DB + 2) armd[i] = 1;
                end else if (sv != dv[i] && run[i] >= DB) begin
                    dv[i] = sv; np[i] = sv;
                end
            end
            pp = np[0]; pr = np[1]; pl = np[2];
        end
    end

    // Every-cycle output comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            nvec++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp || done !== e_done) begin
                nerr++;
                $display("FAIL cycle t=%0t an=%b/%b seg=%b/%b dp=%b/%b done=%b/%b (got/expected)",
                         $time, an, e_an, seg, e_seg, dp, e_dp, done, e_done);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_int(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Caller is just after a negedge; hold the mask 6 cycles, total cycles used = total.
    task automatic press(input logic [2:0] m, input int total);
        {btnL, btnR, btnP} = m;
        repeat (6) @(negedge clk);
        {btnL, btnR, btnP} = 3'b000;
        repeat (total - 6) @(negedge clk);
    endtask

    // Collect one full scan and return the shown digits as decimal MMSS.
    task automatic read_display(output int val);
        int dg [4];
        for (int k = 0; k < 4; k++) dg[k] = 15;
        repeat (DIGITS * SD) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (an == ~(4'b0001 << k)) dg[k] = unpat(seg);
        end
        val = dg[3] * 1000 + dg[2] * 100 + dg[1] * 10 + dg[0];
    endtask

    localparam logic [2:0] KP = 3'b001, KR = 3'b010, KL = 3'b100;
    logic [3:0] scan_exp [4];
    int shown;

    initial begin
        scan_exp[0] = 4'b1101; scan_exp[1] = 4'b1011;
        scan_exp[2] = 4'b0111; scan_exp[3] = 4'b1110;

        // Reset values and scan sequence
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_int("rst_an", int'(an), 4'b1110);
        check_int("rst_seg", int'(seg), 7'b1000000);
        check_int("rst_dp", int'(dp), 1);
        check_int("rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            repeat (2) @(negedge clk);
            check_int("scan_an", int'(an), int'(scan_exp[k]));
        end
        repeat (10) @(negedge clk);

        // Up count 60 ticks then pause 20 ticks
        mode = 1'b0;
        press(KR, 20);
        press(KP, 240);
        press(KP, 80);
        read_display(shown);
        check_int("up60_display", shown, 100);
        check_int("up60_model", m_v, 60);

        // Down count from 01:00 to done, further ticks and P ignored
        mode = 1'b1; sw = 8'h01;
        press(KR, 20);
        press(KP, 250);
        press(KP, 60);
        read_display(shown);
        check_int("down_display", shown, 0);
        check_int("down_done", int'(done), 1);
        check_int("down_model_state", m_st, M_DONE);

        // Preset clamping to 59:00
        sw = 8'h7C;
        press(KR, 20);
        read_display(shown);
        check_int("clamp_display", shown, 5900);
        check_int("clamp_model", m_v, 3540);

        // Zero preset: P goes straight to done
        sw = 8'h00;
        press(KR, 20);
        press(KP, 20);
        check_int("zero_done", int'(done), 1);
        read_display(shown);
        check_int("zero_display", shown, 0);

        // Up wrap 59:59 -> 00:00 and keeps running
        mode = 1'b0;
        press(KR, 20);
        press(KP, 14396);
        press(KP, 20);
        read_display(shown);
        check_int("max_display", shown, 5959);
        check_int("max_model", m_v, 3599);
        press(KP, 12);
        press(KP, 20);
        read_display(shown);
        check_int("wrap_display", shown, 2);
        check_int("wrap_done", int'(done), 0);

        // R and P together in RUN, then a short P glitch
        press(KR, 20);
        press(KP, 40);
        press(KR | KP, 20);
        check_int("rp_model_state", m_st, M_IDLE);
        btnP = 1'b1;
        repeat (2) @(negedge clk);
        btnP = 1'b0;
        repeat (40) @(negedge clk);
        read_display(shown);
        check_int("rp_display", shown, 0);
        check_int("rp_done", int'(done), 0);

        // Lap hold at 00:05 while the count moves on to 00:08
        press(KR, 20);
        press(KP, 22);
        press(KL, 12);
        press(KP, 20);
        read_display(shown);
        check_int("lap_held_display", shown, 5);
        check_int("lap_count_model", m_v, 8);
        press(KL, 20);
        read_display(shown);
        check_int("lap_release_display", shown, 8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
